serial_subtractor: RTL and testbench

//  Bit-serial two's-complement subtractor computing diff = a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_if.sv | 19 +
 rtl/serial_subtractor_full_subtractor.sv | 9 +
 rtl/serial_subtractor.sv | 80 ++++++++
 tb/tb_serial_subtractor.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_sub_pkg: FSM states and the 1-bit full-subtractor cell shape/function shared by the serial subtractor.
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int FS_IN_W = 3;
  localparam int FS_OUT_W = 2;
  // in = {b_in, b, a}; returns {borrow_out, diff}
  function automatic logic [FS_OUT_W-1:0] fs_eval(input logic [FS_IN_W-1:0] i);
    return {(~i[0] & i[1]) | (~(i[0] ^ i[1]) & i[2]), ^i};
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result valid-ready bus; ovf exists only with SERIAL_SUB_OVF_EN.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] diff;
  logic borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, diff, borrow, ovf);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, diff, borrow, ovf);
`else
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, diff, borrow);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: combinational 1-bit full-subtractor cell, port shape mirrors the full adder.
module full_subtractor
  import serial_sub_pkg::*;
(
  input  logic [FS_IN_W-1:0]  in,
  output logic [FS_OUT_W-1:0] out
);
  assign out = fs_eval(in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock; SERIAL_SUB_OVF_EN adds a signed overflow flag.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0] cnt;
  logic br;
  logic d;
  logic br_n;
  logic [FS_OUT_W-1:0] fs_out;
  full_subtractor u_fs (.in({br, b_sh[0], a_sh[0]}), .out(fs_out));
  assign {br_n, d} = fs_out;
  // the borrow flop doubles as the result flag once the last bit has run
  assign bus.borrow = br;
`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      bus.ovf <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
      bus.ovf <= 1'b0;
    end else if (state == RUN && cnt == CW'(WIDTH - 1))
      bus.ovf <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.diff <= '0;
      br <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.in_valid) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            br <= 1'b0;
            cnt <= '0;
            bus.in_ready <= 1'b0;
            state <= RUN;
          end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br <= br_n;
          bus.diff <= {d, bus.diff[WIDTH-1:1]};
          if (cnt == CW'(WIDTH - 1)) begin
            bus.out_valid <= 1'b1;
            state <= DONE;
          end else
            cnt <= cnt + 1'b1;
        end
        DONE:
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table vectors, handshake corner cases and random ops against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic br;
    logic ov;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    logic [W:0] r;
    int s;
    r = {1'b0, a} - {1'b0, b};
    s = int'($signed(a)) - int'($signed(b));
    v.a = a;
    v.b = b;
    v.d = r[W-1:0];
    v.br = r[W];
    v.ov = (s < -(2 ** (W - 1))) || (s > 2 ** (W - 1) - 1);
    return v;
  endfunction
  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_diff"}, 32'(bus.diff), 32'(v.d));
    check({tag, "_borrow"}, 32'(bus.borrow), 32'(v.br));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(v.ov));
`endif
  endtask
  // hold: keep in_valid high throughout; stall: DONE cycles with out_ready low and in_valid pulses
  task automatic op(input string tag, input vec_t v, input bit hold, input int stall);
    int n;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.a = v.a;
    bus.b = v.b;
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), W);
    check_result(tag, v);
    check({tag, "_in_ready_done"}, 32'(bus.in_ready), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.a = ~v.a;
      bus.b = v.a;
      @(posedge clk);
      #1;
      check({tag, "_stall_valid"}, 32'(bus.out_valid), 1);
      check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 0);
      check_result({tag, "_stall"}, v);
    end
    @(negedge clk);
    bus.in_valid = hold;
    bus.a = v.a;
    bus.b = v.b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_handoff_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_handoff_ready"}, 32'(bus.in_ready), 1);
  endtask
  initial begin
    vec_t tbl[4];
    vec_t v;
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_diff", 32'(bus.diff), 0);
    check("rst_borrow", 32'(bus.borrow), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) op($sformatf("tbl%0d", i), tbl[i], 1'b0, 0);
    // back-to-back with in_valid held high through the busy period
    op("b2b0", tbl[3], 1'b1, 0);
    op("b2b1", tbl[0], 1'b0, 0);
    op("stall", tbl[1], 1'b0, 5);
    // early out_ready has no effect before DONE
    bus.out_ready = 1'b1;
    op("early_ready", model(8'h5A, 8'hC3), 1'b0, 0);
    // reset in the middle of RUN
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'hF0;
    bus.b = 8'h0F;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_diff", 32'(bus.diff), 0);
    check("mid_rst_borrow", 32'(bus.borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
    check("mid_rst_ovf", 32'(bus.ovf), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst", '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0}, 1'b0, 0);
    for (int i = 0; i < 24; i++) begin
      v = model(W'($urandom), W'($urandom));
      op($sformatf("rnd%0d", i), v, 1'b0, i % 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
